ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction fetch stage; sits directly upstream of the decode stage.
- Owns the PC register and issues single-outstanding read requests to instruction memory over a valid/ready request channel and a valid response channel.
- Presents each fetched instruction and its PC to decode through a valid/ready output register.
- Accepts a redirect (new PC) from execute at any time and discards in-flight stale responses.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- PC_WIDTH, 32, width of the PC and memory address.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears state immediately.
- redirect_valid  input  1  one-cycle pulse; replace PC with redirect_pc.
- redirect_pc  input  PC_WIDTH  redirect target.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  PC_WIDTH  read address.
- imem_rsp_valid  input  1  read data returned (one cycle pulse).
- imem_rsp_data  input  32  instruction word.
- imem_rsp_err  input  1  access fault on this response.
- inst_valid  output  1  instruction register holds a valid instruction.
- inst_ready  input  1  decode consumes instruction.
- inst  output  32  instruction to decode.
- inst_pc  output  PC_WIDTH  PC of inst.
- inst_fault  output  1  inst came from an erroring or faulting fetch.

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=IDLE, kill=0, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE -> REQ on the first posedge after reset deasserts.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready -> WAIT.
  - While valid and not ready, the address is stable; the only exception is a redirect.
- WAIT:
  - On imem_rsp_valid with kill=0: inst<=imem_rsp_data, inst_pc<=pc, inst_fault<=imem_rsp_err, inst_valid<=1, pc<=pc+4, go to HOLD.
  - On imem_rsp_valid with kill=1: discard the response, clear kill, go to REQ (pc already holds the redirect target).
- HOLD:
  - inst/inst_pc/inst_fault held stable while inst_valid=1.
  - On inst_ready: inst_valid<=0, go to REQ.
  - Next request is issued the cycle after the handshake.
- Latency: request to inst_valid is memory latency + 1 cycle.
  - Zero-wait memory (ready in REQ, rsp next cycle): one instruction every 3 cycles.
- PC arithmetic: modulo 2^PC_WIDTH; 32'hFFFF_FFFC+4 = 0.
- Redirect (takes priority over every simultaneous event); pc<=redirect_pc in every state, plus:
  - IDLE: stays IDLE; the normal reset-exit transition still applies.
  - REQ, not accepted this cycle: stay in REQ; imem_req_addr changes to the new pc next cycle.
  - REQ, accepted this cycle: go to WAIT with kill=1.
  - WAIT: kill<=1. If the response arrives in the same cycle, drop it and go to REQ with kill=0.
  - HOLD: inst_valid<=0 next cycle, go to REQ, even if inst_ready=1 in the same cycle (that instruction is not consumed).
- imem_rsp_valid outside WAIT is ignored.
- Only one request is outstanding at any time.
- Reset asserted mid-transaction returns to the reset state immediately. Any response arriving after reset release, before the first request, is ignored.

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- Defined: in REQ, if pc[1:0]!=0, no memory request is issued (imem_req_valid=0). Next cycle: inst_valid<=1, inst<=0, inst_pc<=pc, inst_fault<=1, go to HOLD; pc is not incremented.
- Undefined: pc[1:0] is not checked; the address is driven as-is.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0013, inst_ready=1 → inst_pc sequence 8000_0000, 8000_0004, 8000_0008 with inst_valid every 3rd cycle.
- inst_ready=0 for 5 cycles in HOLD → inst/inst_pc unchanged, imem_req_valid=0 throughout; on ready=1, next request addr = inst_pc+4.
- Redirect to 32'h8000_0100 while in WAIT, response 32'hDEAD_BEEF arrives 2 cycles later → response dropped (no inst_valid); next request addr 8000_0100.
- Redirect in the same cycle as imem_rsp_valid and in the same cycle as inst_ready in HOLD → no instruction delivered; next request addr = redirect_pc.
- imem_rsp_err=1 on fetch at 8000_0010 → inst_valid=1, inst_fault=1, inst_pc=8000_0010; next fetch 8000_0014.
- With IFU_MISALIGN_CHECK_EN: redirect to 32'h8000_0002 → no memory request, inst_fault=1, inst_pc=8000_0002. Without the macro: request issued at 8000_0002.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem read, and holds the result for decode.
// Optional IFU_MISALIGN_CHECK_EN: a misaligned PC produces a faulting instruction instead of a memory request.
`timescale 1ns/1ps

module ifu_fetch #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                imem_rsp_err,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [PC_WIDTH-1:0] inst_pc,
    output logic                inst_fault
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic                kill;
    logic                misaligned;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Request outputs decode registered state only, so the address is stable until a redirect lands.
    assign imem_req_valid = (state == REQ) && !misaligned;
    assign imem_req_addr  = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc;
            end
            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (redirect_valid) begin
                        // An accepted stale request must have its response dropped later.
                        if (imem_req_valid && imem_req_ready) begin
                            kill  <= 1'b1;
                            state <= WAIT;
                        end
                    end else if (misaligned) begin
                        inst_valid <= 1'b1;
                        inst       <= '0;
                        inst_pc    <= pc;
                        inst_fault <= 1'b1;
                        state      <= HOLD;
                    end else if (imem_req_ready) begin
                        kill  <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        if (imem_rsp_valid) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            inst_valid <= 1'b1;
                            inst       <= imem_rsp_data;
                            inst_pc    <= pc;
                            inst_fault <= imem_rsp_err;
                            pc         <= pc + PC_WIDTH'(4);
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // A redirect discards the held instruction even if decode is ready.
                    if (redirect_valid || inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
